// File: rtl/prt_vtb_mon_lock_if.sv
// prt_vtb_mon_lock_if
//   Bundle between a VTB video stream tap and the timing monitor.
//   Video side: VID_SOF_IN / VID_EOL_IN are qualified by VID_VLD_IN; each
//   valid beat carries P_PPC pixels. The monitor is a passive tap: there is
//   no ready, a beat is taken on every clock where VID_VLD_IN is high.
//   Host side: CLR_IN is a one-cycle pulse; STA_* are the status outputs and
//   DBG_STATE_OUT exposes the lock state machine (0 IDLE, 1 ACQ, 2 LOCK).
//   Modports: master = stream source / host, slave = monitor.
interface prt_vtb_mon_lock_if #(
  parameter int P_CNT_W = 16
);
  logic               VID_SOF_IN;
  logic               VID_EOL_IN;
  logic               VID_VLD_IN;
  logic               CLR_IN;
  logic [P_CNT_W-1:0] STA_PIX_OUT;
  logic [P_CNT_W-1:0] STA_LIN_OUT;
  logic [15:0]        STA_FRM_OUT;
  logic               STA_UPD_OUT;
  logic               STA_LOCK_OUT;
  logic               STA_ERR_OUT;
  logic [P_CNT_W-1:0] STA_HTOT_OUT;
  logic [1:0]         DBG_STATE_OUT;

  modport master (
    output VID_SOF_IN, VID_EOL_IN, VID_VLD_IN, CLR_IN,
    input  STA_PIX_OUT, STA_LIN_OUT, STA_FRM_OUT, STA_UPD_OUT,
    input  STA_LOCK_OUT, STA_ERR_OUT, STA_HTOT_OUT, DBG_STATE_OUT
  );

  modport slave (
    input  VID_SOF_IN, VID_EOL_IN, VID_VLD_IN, CLR_IN,
    output STA_PIX_OUT, STA_LIN_OUT, STA_FRM_OUT, STA_UPD_OUT,
    output STA_LOCK_OUT, STA_ERR_OUT, STA_HTOT_OUT, DBG_STATE_OUT
  );
endinterface

// File: rtl/prt_vtb_mon_lock.sv
// prt_vtb_mon_lock
//   Passive video timing monitor with lock detection. Measures active pixels
//   per line, lines per frame and frames received, and qualifies the stream
//   as stable after P_LOCK_FRM consecutive matching frames.
//   Ports:
//     CLK_IN  video clock
//     RST_IN  asynchronous active-low reset
//     vid     prt_vtb_mon_lock_if.slave (video tap, CLR_IN, STA_* status,
//             DBG_STATE_OUT state machine view)
//   Optional feature: define PRT_VTB_MON_LOCK_HTOT_EN to measure clocks per
//   line (times P_PPC) on STA_HTOT_OUT; otherwise STA_HTOT_OUT is tied to 0.
module prt_vtb_mon_lock #(
  parameter int P_PPC      = 2,
  parameter int P_CNT_W    = 16,
  parameter int P_LOCK_FRM = 4,
  parameter int P_TMO_CLK  = 2**22
) (
  input logic               CLK_IN,
  input logic               RST_IN,
  prt_vtb_mon_lock_if.slave vid
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam int                 TMO_W    = $clog2(P_TMO_CLK + 1);
  localparam logic [TMO_W-1:0]   TMO_END  = TMO_W'(P_TMO_CLK);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(P_TMO_CLK - 1);
  localparam logic [P_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [P_CNT_W:0]   PPC_VAL  = (P_CNT_W+1)'(P_PPC);
  localparam logic [4:0]         LOCK_N   = 5'(P_LOCK_FRM);

  logic               sof_r, eol_r, vld_r;
  logic               sof_b, eol_b;
  logic [P_CNT_W-1:0] run_pix, run_lin, ref_pix;
  logic               first_ln, irr, opened;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [1:0]         state;
  logic [3:0]         match_cnt;
  logic [4:0]         match_inc;
  logic [P_CNT_W:0]   pix_sum;
  logic [P_CNT_W-1:0] line_len;
  logic               line_first, irr_evt, pub, tmo_fire;
  logic               htot_match, match, err_set;
  logic [P_CNT_W-1:0] sta_pix, sta_lin;
  logic [15:0]        sta_frm;
  logic               sta_upd, sta_lock, sta_err;

  always_comb begin
    sof_b      = vld_r & sof_r;
    eol_b      = vld_r & eol_r;
    pix_sum    = {1'b0, run_pix} + PPC_VAL;
    line_len   = pix_sum[P_CNT_W] ? CNT_MAX : pix_sum[P_CNT_W-1:0];
    // A line ending on the SOF beat is the first line of the new frame.
    line_first = sof_b | first_ln;
    irr_evt    = eol_b & ~line_first & (line_len != ref_pix);
    pub        = sof_b & opened;
    tmo_fire   = (tmo_cnt == TMO_LAST) & ~sof_b;
    // Closed-frame values are compared against the still-published ones.
    match      = ~irr & (ref_pix == sta_pix) & (run_lin == sta_lin) & htot_match;
    match_inc  = {1'b0, match_cnt} + 5'd1;
    err_set    = (irr_evt & (state != ST_IDLE)) |
                 (pub & ~match & (state == ST_LOCK));
  end

  // Input stage and frame measurement.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      sof_r    <= 1'b0;
      eol_r    <= 1'b0;
      vld_r    <= 1'b0;
      run_pix  <= '0;
      run_lin  <= '0;
      ref_pix  <= '0;
      first_ln <= 1'b0;
      irr      <= 1'b0;
      opened   <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      sof_r <= vid.VID_SOF_IN;
      eol_r <= vid.VID_EOL_IN;
      vld_r <= vid.VID_VLD_IN;

      if (sof_b)                  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_END) tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (vld_r) run_pix <= eol_r ? '0 : line_len;
      if (eol_b && line_first) ref_pix <= line_len;

      if (sof_b)      first_ln <= ~eol_b;
      else if (eol_b) first_ln <= 1'b0;

      if (sof_b)        irr <= 1'b0;
      else if (irr_evt) irr <= 1'b1;

      if (sof_b)                             run_lin <= eol_b ? P_CNT_W'(1) : '0;
      else if (eol_b && run_lin != CNT_MAX) run_lin <= run_lin + P_CNT_W'(1);

      if (tmo_fire)   opened <= 1'b0;
      else if (sof_b) opened <= 1'b1;
    end
  end

  // Publishing, lock state machine and error flag.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
      sta_pix   <= '0;
      sta_lin   <= '0;
      sta_frm   <= '0;
      sta_upd   <= 1'b0;
      sta_lock  <= 1'b0;
      sta_err   <= 1'b0;
    end else begin
      sta_upd <= pub;
      // A set on the same clock as CLR_IN wins.
      if (err_set)         sta_err <= 1'b1;
      else if (vid.CLR_IN) sta_err <= 1'b0;

      if (pub) begin
        sta_pix <= ref_pix;
        sta_lin <= run_lin;
        sta_frm <= sta_frm + 16'd1;
      end

      if (tmo_fire) begin
        state     <= ST_IDLE;
        match_cnt <= '0;
        sta_lock  <= 1'b0;
        sta_pix   <= '0;
        sta_lin   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sof_b) begin
              state     <= ST_ACQ;
              match_cnt <= '0;
            end
          end
          ST_ACQ: begin
            if (pub) begin
              if (match) begin
                match_cnt <= match_inc[3:0];
                if (match_inc >= LOCK_N) begin
                  state    <= ST_LOCK;
                  sta_lock <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          ST_LOCK: begin
            if (pub && !match) begin
              state     <= ST_ACQ;
              sta_lock  <= 1'b0;
              match_cnt <= '0;
            end
          end
          default: begin
            state    <= ST_IDLE;
            sta_lock <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PRT_VTB_MON_LOCK_HTOT_EN
  logic [P_CNT_W-1:0] hclk_cnt, htot_line, sta_htot, htot_sat;
  logic [P_CNT_W+2:0] htot_prod;

  // hclk_cnt holds clocks since the previous EOL beat minus one, so the
  // line period is hclk_cnt + 1 at the closing EOL beat.
  always_comb begin
    htot_prod  = ({3'b000, hclk_cnt} + (P_CNT_W+3)'(1)) * (P_CNT_W+3)'(P_PPC);
    htot_sat   = (htot_prod > {3'b000, CNT_MAX}) ? CNT_MAX : htot_prod[P_CNT_W-1:0];
    htot_match = (htot_line == sta_htot);
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      hclk_cnt  <= '0;
      htot_line <= '0;
      sta_htot  <= '0;
    end else begin
      if (eol_b)                     hclk_cnt <= '0;
      else if (hclk_cnt != CNT_MAX) hclk_cnt <= hclk_cnt + P_CNT_W'(1);
      if (eol_b) htot_line <= htot_sat;
      if (tmo_fire) sta_htot <= '0;
      else if (pub) sta_htot <= htot_line;
    end
  end

  assign vid.STA_HTOT_OUT = sta_htot;
`else
  assign htot_match       = 1'b1;
  assign vid.STA_HTOT_OUT = '0;
`endif

  assign vid.STA_PIX_OUT   = sta_pix;
  assign vid.STA_LIN_OUT   = sta_lin;
  assign vid.STA_FRM_OUT   = sta_frm;
  assign vid.STA_UPD_OUT   = sta_upd;
  assign vid.STA_LOCK_OUT  = sta_lock;
  assign vid.STA_ERR_OUT   = sta_err;
  assign vid.DBG_STATE_OUT = state;
endmodule

// File: tb/tb_prt_vtb_mon_lock.sv
// tb_prt_vtb_mon_lock
//   Bench for prt_vtb_mon_lock. dut: P_PPC=2, frames of FPX px x FLN lines,
//   P_TMO_CLK=1000. dut4: P_PPC=4, one-line frames with SOF and EOL on the
//   same beat and 2 idle clocks per line. Published frames are predicted
//   when the SOF beat is driven and checked when STA_UPD_OUT pulses.
`timescale 1ns/1ps
module tb_prt_vtb_mon_lock;
  localparam int FPX = 16;
  localparam int FLN = 6;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prt_vtb_mon_lock_if #(.P_CNT_W(16)) vif2 ();
  prt_vtb_mon_lock_if #(.P_CNT_W(16)) vif4 ();

  prt_vtb_mon_lock #(.P_PPC(2), .P_CNT_W(16), .P_LOCK_FRM(4), .P_TMO_CLK(1000)) dut (
    .CLK_IN(clk), .RST_IN(rst_n), .vid(vif2)
  );
  prt_vtb_mon_lock #(.P_PPC(4), .P_CNT_W(16), .P_LOCK_FRM(4), .P_TMO_CLK(1000)) dut4 (
    .CLK_IN(clk), .RST_IN(rst_n), .vid(vif4)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int upd4_cnt = 0;

  // Scoreboard entry: {due cycle, frm, lin, pix}
  logic [79:0] exp_q[$];
  int mdl_frm  = 0;
  bit mdl_open = 1'b0;
  int prev_pix = 0;
  int prev_lin = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every publish must match the oldest prediction.
  always @(negedge clk) begin
    logic [79:0] e;
    if (rst_n && vif4.STA_UPD_OUT === 1'b1) upd4_cnt++;
    if (rst_n && vif2.STA_UPD_OUT === 1'b1) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_upd: got upd=1 at cycle %0d, required no publish", cyc);
      end else begin
        e = exp_q.pop_front();
        n_assert++;
        if (vif2.STA_PIX_OUT !== e[15:0]) begin
          n_fail++; $display("FAIL sb_pix: got %0d, required %0d", vif2.STA_PIX_OUT, e[15:0]);
        end
        n_assert++;
        if (vif2.STA_LIN_OUT !== e[31:16]) begin
          n_fail++; $display("FAIL sb_lin: got %0d, required %0d", vif2.STA_LIN_OUT, e[31:16]);
        end
        n_assert++;
        if (vif2.STA_FRM_OUT !== e[47:32]) begin
          n_fail++; $display("FAIL sb_frm: got %0d, required %0d", vif2.STA_FRM_OUT, e[47:32]);
        end
        n_assert++;
        if (cyc !== int'(e[79:48])) begin
          n_fail++; $display("FAIL sb_latency: upd at cycle %0d, required cycle %0d", cyc, e[79:48]);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive2(input bit sof, input bit eol, input bit vld, input bit clr);
    @(negedge clk);
    vif2.VID_SOF_IN = sof;
    vif2.VID_EOL_IN = eol;
    vif2.VID_VLD_IN = vld;
    vif2.CLR_IN     = clr;
  endtask

  task automatic drive4(input bit sof, input bit eol, input bit vld);
    @(negedge clk);
    vif4.VID_SOF_IN = sof;
    vif4.VID_EOL_IN = eol;
    vif4.VID_VLD_IN = vld;
  endtask

  task automatic send_frame(input int lines, input int short_line, input int short_px);
    int px;
    for (int l = 0; l < lines; l++) begin
      px = (l == short_line) ? short_px : FPX;
      for (int b = 0; b < px / 2; b++) begin
        drive2(l == 0 && b == 0, b == px / 2 - 1, 1'b1, 1'b0);
        if (l == 0 && b == 0) begin
          if (mdl_open) begin
            mdl_frm = (mdl_frm + 1) & 16'hffff;
            exp_q.push_back({32'(cyc + 2), 16'(mdl_frm), 16'(prev_lin), 16'(prev_pix)});
          end
          mdl_open = 1'b1;
        end
      end
    end
    prev_lin = lines;
    prev_pix = FPX;
  endtask

  // Scenarios
  task automatic test_reset;
    vif2.VID_SOF_IN = 0; vif2.VID_EOL_IN = 0; vif2.VID_VLD_IN = 0; vif2.CLR_IN = 0;
    vif4.VID_SOF_IN = 0; vif4.VID_EOL_IN = 0; vif4.VID_VLD_IN = 0; vif4.CLR_IN = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (vif2.STA_PIX_OUT !== 16'd0 || vif2.STA_LIN_OUT !== 16'd0 || vif2.STA_FRM_OUT !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got pix=%0d lin=%0d frm=%0d, required 0", vif2.STA_PIX_OUT, vif2.STA_LIN_OUT, vif2.STA_FRM_OUT);
    end
    n_assert++;
    if (vif2.STA_UPD_OUT !== 1'b0 || vif2.STA_LOCK_OUT !== 1'b0 || vif2.STA_ERR_OUT !== 1'b0 || vif2.STA_HTOT_OUT !== 16'd0) begin
      n_fail++; $display("FAIL reset_flags: got upd=%b lock=%b err=%b htot=%0d, required 0", vif2.STA_UPD_OUT, vif2.STA_LOCK_OUT, vif2.STA_ERR_OUT, vif2.STA_HTOT_OUT);
    end
    n_assert++;
    if (vif2.DBG_STATE_OUT !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d, required 0", vif2.DBG_STATE_OUT);
    end
    n_assert++;
    if (vif4.STA_PIX_OUT !== 16'd0 || vif4.STA_FRM_OUT !== 16'd0 || vif4.STA_LOCK_OUT !== 1'b0 || vif4.STA_HTOT_OUT !== 16'd0) begin
      n_fail++; $display("FAIL reset_dut4: got pix=%0d frm=%0d lock=%b htot=%0d, required 0", vif4.STA_PIX_OUT, vif4.STA_FRM_OUT, vif4.STA_LOCK_OUT, vif4.STA_HTOT_OUT);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stable;
    repeat (5) send_frame(FLN, -1, 0);
    n_assert++;
    if (vif2.STA_LOCK_OUT !== 1'b0) begin
      n_fail++; $display("FAIL stable_nolock_4pub: got lock=%b, required 0", vif2.STA_LOCK_OUT);
    end
    send_frame(FLN, -1, 0);
    n_assert++;
    if (vif2.STA_LOCK_OUT !== 1'b1 || vif2.DBG_STATE_OUT !== 2'd2) begin
      n_fail++; $display("FAIL stable_lock_5pub: got lock=%b state=%0d, required 1/2", vif2.STA_LOCK_OUT, vif2.DBG_STATE_OUT);
    end
    n_assert++;
    if (vif2.STA_ERR_OUT !== 1'b0) begin
      n_fail++; $display("FAIL stable_err: got %b, required 0", vif2.STA_ERR_OUT);
    end
  endtask

  task automatic test_lin_err;
    send_frame(FLN - 1, -1, 0);
    n_assert++;
    if (vif2.STA_LOCK_OUT !== 1'b1 || vif2.STA_ERR_OUT !== 1'b0) begin
      n_fail++; $display("FAIL linerr_before_pub: got lock=%b err=%b, required 1/0", vif2.STA_LOCK_OUT, vif2.STA_ERR_OUT);
    end
    send_frame(FLN, -1, 0);
    n_assert++;
    if (vif2.STA_LOCK_OUT !== 1'b0 || vif2.STA_ERR_OUT !== 1'b1 || vif2.DBG_STATE_OUT !== 2'd1) begin
      n_fail++; $display("FAIL linerr_drop: got lock=%b err=%b state=%0d, required 0/1/1", vif2.STA_LOCK_OUT, vif2.STA_ERR_OUT, vif2.DBG_STATE_OUT);
    end
    repeat (4) send_frame(FLN, -1, 0);
    n_assert++;
    if (vif2.STA_LOCK_OUT !== 1'b0) begin
      n_fail++; $display("FAIL linerr_early_relock: got lock=%b, required 0", vif2.STA_LOCK_OUT);
    end
    send_frame(FLN, -1, 0);
    n_assert++;
    if (vif2.STA_LOCK_OUT !== 1'b1 || vif2.STA_ERR_OUT !== 1'b1) begin
      n_fail++; $display("FAIL linerr_relock: got lock=%b err=%b, required 1/1", vif2.STA_LOCK_OUT, vif2.STA_ERR_OUT);
    end
    drive2(1'b0, 1'b0, 1'b0, 1'b1);
    drive2(1'b0, 1'b0, 1'b0, 1'b0);
    n_assert++;
    if (vif2.STA_ERR_OUT !== 1'b0 || vif2.STA_LOCK_OUT !== 1'b1) begin
      n_fail++; $display("FAIL linerr_clr: got err=%b lock=%b, required 0/1", vif2.STA_ERR_OUT, vif2.STA_LOCK_OUT);
    end
  endtask

  task automatic test_irregular;
    send_frame(FLN, 2, FPX - 2);
    n_assert++;
    if (vif2.STA_ERR_OUT !== 1'b1) begin
      n_fail++; $display("FAIL irr_err: got %b, required 1", vif2.STA_ERR_OUT);
    end
    send_frame(FLN, -1, 0);
    n_assert++;
    if (vif2.STA_LOCK_OUT !== 1'b0 || vif2.DBG_STATE_OUT !== 2'd1) begin
      n_fail++; $display("FAIL irr_nomatch: got lock=%b state=%0d, required 0/1", vif2.STA_LOCK_OUT, vif2.DBG_STATE_OUT);
    end
  endtask

  task automatic test_timeout;
    repeat (1100) drive2(1'b0, 1'b0, 1'b0, 1'b0);
    mdl_open = 1'b0;
    n_assert++;
    if (vif2.DBG_STATE_OUT !== 2'd0 || vif2.STA_LOCK_OUT !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idle: got state=%0d lock=%b, required 0/0", vif2.DBG_STATE_OUT, vif2.STA_LOCK_OUT);
    end
    n_assert++;
    if (vif2.STA_PIX_OUT !== 16'd0 || vif2.STA_LIN_OUT !== 16'd0 || vif2.STA_HTOT_OUT !== 16'd0) begin
      n_fail++; $display("FAIL tmo_clear: got pix=%0d lin=%0d htot=%0d, required 0", vif2.STA_PIX_OUT, vif2.STA_LIN_OUT, vif2.STA_HTOT_OUT);
    end
    n_assert++;
    if (vif2.STA_FRM_OUT !== 16'(mdl_frm)) begin
      n_fail++; $display("FAIL tmo_frm_held: got %0d, required %0d", vif2.STA_FRM_OUT, mdl_frm);
    end
    send_frame(FLN, -1, 0);
    n_assert++;
    if (vif2.STA_PIX_OUT !== 16'd0 || vif2.STA_FRM_OUT !== 16'(mdl_frm)) begin
      n_fail++; $display("FAIL tmo_first_sof: got pix=%0d frm=%0d, required 0/%0d", vif2.STA_PIX_OUT, vif2.STA_FRM_OUT, mdl_frm);
    end
    send_frame(FLN, -1, 0);
  endtask

  task automatic test_async_reset;
    send_frame(FLN, -1, 0);
    repeat (5) drive2(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (vif2.STA_FRM_OUT !== 16'd0 || vif2.STA_PIX_OUT !== 16'd0 || vif2.STA_LIN_OUT !== 16'd0 || vif2.DBG_STATE_OUT !== 2'd0) begin
      n_fail++; $display("FAIL async_rst: got frm=%0d pix=%0d lin=%0d state=%0d, required 0", vif2.STA_FRM_OUT, vif2.STA_PIX_OUT, vif2.STA_LIN_OUT, vif2.DBG_STATE_OUT);
    end
    vif2.VID_SOF_IN = 0; vif2.VID_EOL_IN = 0; vif2.VID_VLD_IN = 0;
    exp_q.delete();
    mdl_frm  = 0;
    mdl_open = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) send_frame(FLN, -1, 0);
    n_assert++;
    if (vif2.STA_FRM_OUT !== 16'd1 || vif2.STA_PIX_OUT !== 16'(FPX)) begin
      n_fail++; $display("FAIL async_restart: got frm=%0d pix=%0d, required 1/%0d", vif2.STA_FRM_OUT, vif2.STA_PIX_OUT, FPX);
    end
  endtask

  task automatic test_ppc4_same_beat;
    logic [15:0] exp_htot;
`ifdef PRT_VTB_MON_LOCK_HTOT_EN
    exp_htot = 16'd40;
`else
    exp_htot = 16'd0;
`endif
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 8; b++) drive4(b == 7, b == 7, 1'b1);
      repeat (2) drive4(1'b0, 1'b0, 1'b0);
    end
    repeat (3) drive4(1'b0, 1'b0, 1'b0);
    n_assert++;
    if (vif4.STA_LIN_OUT !== 16'd1 || vif4.STA_PIX_OUT !== 16'd32) begin
      n_fail++; $display("FAIL ppc4_geom: got lin=%0d pix=%0d, required 1/32", vif4.STA_LIN_OUT, vif4.STA_PIX_OUT);
    end
    n_assert++;
    if (vif4.STA_FRM_OUT !== 16'd3 || upd4_cnt !== 3) begin
      n_fail++; $display("FAIL ppc4_frm: got frm=%0d upd_pulses=%0d, required 3/3", vif4.STA_FRM_OUT, upd4_cnt);
    end
    n_assert++;
    if (vif4.STA_HTOT_OUT !== exp_htot) begin
      n_fail++; $display("FAIL ppc4_htot: got %0d, required %0d", vif4.STA_HTOT_OUT, exp_htot);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stable();
    test_lin_err();
    test_irregular();
    test_timeout();
    test_async_reset();
    test_ppc4_same_beat();
    repeat (4) @(negedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d pending publishes, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/prt_vtb_mon_lock.md
Name: prt_vtb_mon_lock

Overview:
- Parametrised video timing monitor with lock detection for the video toolbox.
- Sits on a VTB video stream as a passive tap and measures active pixels per line, lines per frame and frames received.
- Qualifies the stream as stable, and reports lock and error status to the host register block.
- Supports 1/2/4 pixels per clock and configurable counter widths.

Parameters:
- P_PPC, 2, pixels per clock; legal values 1, 2, 4.
- P_CNT_W, 16, width of the pixel and line counters and status outputs.
- P_LOCK_FRM, 4, consecutive matching frames required to assert lock; legal range 1..15.
- P_TMO_CLK, 2**22, clocks without a valid SOF beat before the monitor returns to IDLE.

Ports:
- CLK_IN  in  1  video clock.
- RST_IN  in  1  reset, asynchronous, active-low.
- VID_SOF_IN  in  1  start of frame, qualified by VID_VLD_IN.
- VID_EOL_IN  in  1  end of line, qualified by VID_VLD_IN.
- VID_VLD_IN  in  1  beat valid; each valid beat carries P_PPC pixels.
- CLR_IN  in  1  single-cycle pulse; clears STA_ERR_OUT.
- STA_PIX_OUT  out  P_CNT_W  active pixels per line of the last complete frame.
- STA_LIN_OUT  out  P_CNT_W  lines in the last complete frame.
- STA_FRM_OUT  out  16  frame counter.
- STA_UPD_OUT  out  1  one-cycle pulse when new STA values are published.
- STA_LOCK_OUT  out  1  stream stable.
- STA_ERR_OUT  out  1  sticky lock-loss or irregular-frame flag.
- STA_HTOT_OUT  out  P_CNT_W  clocks per line times P_PPC; only driven by the optional feature.

Behaviour:
- Reset:
  - All outputs 0.
  - All counters 0.
  - State machine in IDLE.
- Input stage: SOF, EOL and VLD are registered one stage. All logic below operates on the registered beat; "beat" means registered VLD=1.
- Pixel run counter (run_pix):
  - Beat without EOL: run_pix += P_PPC.
  - Beat with EOL: line length = run_pix + P_PPC, then run_pix <= 0.
  - The counter saturates at all-ones and does not wrap.
- Line regularity:
  - The first line length of each frame is stored as ref_pix.
  - Any later line in the same frame whose length differs from ref_pix sets the frame's irr flag.
- Line run counter (run_lin): incremented on each EOL beat and saturates at all-ones.
- SOF beat closes the previous frame and opens a new one:
  - Frame values: lin = run_lin, pix = ref_pix.
  - run_lin and irr are cleared.
  - If SOF and EOL fall on the same beat, the closed frame uses run_lin before the increment, and the new frame starts with run_lin = 1.
- Publishing:
  - The first SOF after reset or after timeout only opens a frame; nothing is published.
  - Every later SOF publishes the frame values: STA_PIX_OUT and STA_LIN_OUT update, STA_FRM_OUT increments (16-bit wrap), and STA_UPD_OUT pulses for one clock.
  - Latency is 2 clocks from the VID_SOF_IN beat to the STA_* update.
- Frame match condition: irr=0, pix equals the previously published pix, and lin equals the previously published lin. Compare against the old values before they are overwritten.
- State machine:
  - IDLE: on SOF -> ACQ, match_cnt = 0.
  - ACQ, on publish:
    - Match: match_cnt++. When match_cnt reaches P_LOCK_FRM -> LOCK, STA_LOCK_OUT = 1.
    - No match: match_cnt = 0.
  - LOCK, on publish:
    - Match: stay in LOCK.
    - No match: -> ACQ, STA_LOCK_OUT = 0, match_cnt = 0, STA_ERR_OUT = 1.
  - An irregular frame sets STA_ERR_OUT in any state except IDLE.
  - Timeout (any state): the timeout counter counts clocks since the last SOF beat. At P_TMO_CLK -> IDLE, STA_LOCK_OUT = 0, and STA_PIX_OUT, STA_LIN_OUT and STA_HTOT_OUT are cleared. STA_FRM_OUT is held.
- STA_ERR_OUT priority: CLR_IN clears it; a simultaneous set wins over the clear.
- VLD low beats are ignored by the pixel, line and frame counters. Only the timeout counter and HTOT advance.
- Asynchronous reset mid-frame returns the block to its full reset state immediately. The partial frame is discarded.

Optional Feature:
- Macro: PRT_VTB_MON_LOCK_HTOT_EN.
- Defined:
  - A clock counter runs between consecutive registered EOL beats, including VLD-low clocks.
  - On each EOL beat, the last line's value count*P_PPC is stored.
  - STA_HTOT_OUT takes the stored value at publish and saturates at all-ones.
  - An HTOT change between frames also counts as no match for locking.
- Undefined: STA_HTOT_OUT is tied to 0 and no HTOT logic is synthesised.

Test Plan:
- P_PPC=2, frames of 1920 px x 1080 lines, gapless:
  - The first SOF publishes nothing.
  - From the 2nd SOF onward: STA_PIX_OUT=1920, STA_LIN_OUT=1080, STA_UPD_OUT pulses once per frame 2 clocks after SOF, STA_FRM_OUT=1,2,...
- P_LOCK_FRM=4, repeated stable frames: STA_LOCK_OUT rises at the 5th publish (4th match) and STA_ERR_OUT stays 0.
- Locked, then one frame of 1079 lines: lock drops at that publish, STA_ERR_OUT=1, and lock is regained after 4 further good frames. A CLR_IN pulse then clears STA_ERR_OUT.
- One line of 1918 px inside a frame: STA_ERR_OUT=1, that frame does not count as a match, and STA_PIX_OUT reports the first line (1920).
- Stream stopped beyond P_TMO_CLK (bench sets P_TMO_CLK=1000): state goes to IDLE, lock=0, PIX/LIN=0, FRM held. On restart, the first publish occurs on the 2nd SOF.
- P_PPC=4, 1-line frames with SOF and EOL on the same beat, 8 beats per line:
  - STA_LIN_OUT=1, STA_PIX_OUT=32.
  - With PRT_VTB_MON_LOCK_HTOT_EN and 2 idle clocks per line: STA_HTOT_OUT=40.
